sync_fifo_ext: RTL

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO. It adds programmable almost-full/almost-empty thresholds, an occupancy count, and one-cycle overflow/underflow error pulses. A compile-time mode selects registered (standard) read data or first-word-fall-through read data. It sits between same-clock producer/consumer blocks wherever rate smoothing with early back-pressure is needed.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_ext_if.sv | 39 +++
 rtl/sync_fifo_mem.sv | 36 +++
 rtl/sync_fifo_ext.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared helpers and default threshold margins for the
//               sync_fifo_ext family.
//               cnt_width(depth) -> occupancy counter width, clog2(depth)+1,
//               wide enough to hold the value DEPTH itself.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Default distance of the almost-full level below DEPTH and of the
    // almost-empty level above zero.
    localparam int AF_MARGIN = 2;
    localparam int AE_MARGIN = 2;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ext_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ext_if
// Description : Data/handshake/status bundle of sync_fifo_ext.
//               master : producer/consumer side (drives data_in, wr_en, rd_en)
//               slave  : FIFO side (drives data_out, flags, count, errors)
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_ext_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic [WIDTH-1:0]            data_in;
    logic                        wr_en;
    logic                        rd_en;
    logic [WIDTH-1:0]            data_out;
    logic                        full;
    logic                        empty;
    logic                        almost_full;
    logic                        almost_empty;
    logic [cnt_width(DEPTH)-1:0] count;
    logic                        overflow;
    logic                        underflow;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x WIDTH register array, one write and one read port.
//               Synchronous write, combinational read by address. Contents
//               are deliberately not reset.
//   clk       : rising-edge clock
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write data
//   i_raddr   : read address
//   o_rdata   : read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ext
// Description : Single-clock FIFO with occupancy count, programmable
//               almost-full/almost-empty levels, one-cycle overflow and
//               underflow pulses, and a compile-time registered or
//               first-word-fall-through read mode.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   fifo_if   : slave side of sync_fifo_ext_if
//               (data_in/wr_en/rd_en in; data_out, full, empty,
//                almost_full, almost_empty, count, overflow, underflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - AF_MARGIN,
    parameter int AE_LEVEL = AE_MARGIN,
    parameter int FWFT     = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    sync_fifo_ext_if.slave  fifo_if
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = cnt_width(DEPTH);

    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF_CNT   = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE_CNT   = c_CW'(AE_LEVEL);

    logic [c_AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CW-1:0] r_count_q,  w_count_d;
    logic            r_overflow_q,  w_overflow_d;
    logic            r_underflow_q, w_underflow_d;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [WIDTH-1:0] w_mem_rdata;

    // Flags decode straight from the registered count, so they move on the
    // same edge as count.
    assign w_full  = (r_count_q == c_FULL_CNT);
    assign w_empty = (r_count_q == '0);

    // Acceptance looks only at the current state: a simultaneous read does
    // not make room for a write while full, and a simultaneous write does
    // not supply data for a read while empty.
    assign w_wr_acc = fifo_if.wr_en && !w_full;
    assign w_rd_acc = fifo_if.rd_en && !w_empty;

    always_comb begin
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;
        w_overflow_d  = fifo_if.wr_en && w_full;
        w_underflow_d = fifo_if.rd_en && w_empty;

        // Pointers are exactly log2(DEPTH) bits and wrap on their own.
        if (w_wr_acc) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end

        if (w_wr_acc && !w_rd_acc) begin
            w_count_d = r_count_q + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_d = r_count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_count_q     <= '0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_count_q     <= w_count_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr_q),
        .i_wdata (fifo_if.data_in),
        .i_raddr (r_rd_ptr_q),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft_read
            // Head word is always presented; a read pops what is on display.
            assign fifo_if.data_out = w_empty ? '0 : w_mem_rdata;
        end else begin : g_std_read
            logic [WIDTH-1:0] r_data_q, w_data_d;

            // Holds across idle cycles and rejected reads.
            always_comb begin
                w_data_d = r_data_q;
                if (w_rd_acc) begin
                    w_data_d = w_mem_rdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_q <= '0;
                end else begin
                    r_data_q <= w_data_d;
                end
            end

            assign fifo_if.data_out = r_data_q;
        end
    endgenerate

    assign fifo_if.full         = w_full;
    assign fifo_if.empty        = w_empty;
    assign fifo_if.almost_full  = (r_count_q >= c_AF_CNT);
    assign fifo_if.almost_empty = (r_count_q <= c_AE_CNT);
    assign fifo_if.count        = r_count_q;
    assign fifo_if.overflow     = r_overflow_q;
    assign fifo_if.underflow    = r_underflow_q;
endmodule
`default_nettype wire
